// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the asynchronous SRAM controller: FSM state encoding,
// pad buffer direction constants and wait-counter width.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_STROBE  = 3'd1,
    S_RD_CAPTURE = 3'd2,
    S_WR_SETUP   = 3'd3,
    S_WR_PULSE   = 3'd4,
    S_WR_HOLD    = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  // pad_t_o polarity of the bidirectional pad buffer: 1 floats the pin.
  localparam logic PAD_HIGHZ = 1'b1;
  localparam logic PAD_DRIVE = 1'b0;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/sram_ctrl.sv
// Single-access asynchronous SRAM controller: one read or write per request,
// strobe length set by WAIT_CYCLES, every output driven straight from a flop.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [DATA_W-1:0] pad_i_o,
  output logic              pad_t_o,
  input  logic [DATA_W-1:0] pad_o_i,
  output logic [2:0]        dbg_state_o
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("sram_ctrl: WAIT_CYCLES must lie in 1..15");
  end

  // The counter holds the strobe cycles still to go after the current one.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  assign dbg_state_o = state;

  // Handshake: req_i is a level sampled on a rising edge only while busy_o is
  // low (IDLE or DONE); when sampled high the access is taken and busy_o rises
  // on the same edge. done_o pulses for exactly one cycle per completed access,
  // and for reads rdata_o is valid from that cycle until the next read ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rdata_o     <= '0;
      sram_addr_o <= '0;
      sram_ce_n_o <= 1'b1;
      sram_oe_n_o <= 1'b1;
      sram_we_n_o <= 1'b1;
      pad_i_o     <= '0;
      pad_t_o     <= PAD_HIGHZ;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          sram_we_n_o <= 1'b1;
          if (req_i) begin
            sram_addr_o <= addr_i;
            wait_cnt    <= WAIT_LAST;
            busy_o      <= 1'b1;
            sram_ce_n_o <= 1'b0;
            if (we_i) begin
              state       <= S_WR_SETUP;
              pad_i_o     <= wdata_i;
              pad_t_o     <= PAD_DRIVE;
              sram_oe_n_o <= 1'b1;
            end else begin
              state       <= S_RD_STROBE;
              pad_t_o     <= PAD_HIGHZ;
              sram_oe_n_o <= 1'b0;
            end
          end else begin
            state       <= S_IDLE;
            busy_o      <= 1'b0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            pad_t_o     <= PAD_HIGHZ;
          end
        end

        S_RD_STROBE: begin
          if (wait_cnt == '0) begin
            state <= S_RD_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        // Pad data has settled for the whole strobe; sample it as OE releases.
        S_RD_CAPTURE: begin
          state       <= S_DONE;
          rdata_o     <= pad_o_i;
          done_o      <= 1'b1;
          busy_o      <= 1'b0;
          sram_ce_n_o <= 1'b1;
          sram_oe_n_o <= 1'b1;
        end

        S_WR_SETUP: begin
          state       <= S_WR_PULSE;
          sram_we_n_o <= 1'b0;
        end

        S_WR_PULSE: begin
          if (wait_cnt == '0) begin
            state       <= S_WR_HOLD;
            sram_we_n_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        // Data stays on the bus one cycle past the WE rising edge.
        S_WR_HOLD: begin
          state       <= S_DONE;
          done_o      <= 1'b1;
          busy_o      <= 1'b0;
          sram_ce_n_o <= 1'b1;
          pad_t_o     <= PAD_HIGHZ;
        end

        default: begin
          state       <= S_IDLE;
          busy_o      <= 1'b0;
          sram_ce_n_o <= 1'b1;
          sram_oe_n_o <= 1'b1;
          sram_we_n_o <= 1'b1;
          pad_t_o     <= PAD_HIGHZ;
        end
      endcase
    end
  end

endmodule
